// File: rtl/dff_scan_pkg.sv
// Shared types and helpers for the DFF scan readback unloader.
package dff_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/dff_scan_shreg.sv
// Load/shift-right shadow register holding the captured flop q vector.
module dff_scan_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_dout,
  output logic             o_dout_nxt
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift_en) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign o_dout     = r_q[0];
  // Bit that becomes dout after a shift; lets the top register tx_bit.
  assign o_dout_nxt = r_q[1];

endmodule

// File: rtl/dff_scan_unloader.sv
// Snapshots a flop bank's q vector and streams it LSB-first over valid/ready,
// optionally followed by an even-parity bit.
module dff_scan_unloader
  import dff_scan_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_req,
  input  logic [WIDTH-1:0] q_in,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  scan_state_e   r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_par, w_par_n;
  logic          r_tx_valid, r_tx_bit, r_tx_last, r_busy, r_done;
  logic          w_valid_n, w_bit_n, w_last_n, w_busy_n, w_done_n;
  logic          w_load, w_shift, w_dout, w_dout_nxt;

  dff_scan_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift_en (w_shift),
    .i_din      (q_in),
    .o_dout     (w_dout),
    .o_dout_nxt (w_dout_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_par      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_bit   <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_par      <= w_par_n;
      r_tx_valid <= w_valid_n;
      r_tx_bit   <= w_bit_n;
      r_tx_last  <= w_last_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_par_n   = r_par;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_valid_n = 1'b0;
    w_bit_n   = 1'b0;
    w_last_n  = 1'b0;

    case (r_state)
      IDLE: begin
        if (capture_req) begin
          w_load    = 1'b1;
          w_cnt_n   = '0;
          w_par_n   = ^q_in;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        // tx_valid is always high here, so tx_ready alone means accepted
        if (tx_ready) begin
          w_shift = 1'b1;
          if (r_cnt == LAST) begin
            w_state_n = PARITY_EN ? PAR : DONE;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      PAR: begin
        if (tx_ready) w_state_n = DONE;
      end
      DONE: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase

    // Outputs are precomputed from the next state so they come out registered.
    case (w_state_n)
      SHIFT: begin
        w_valid_n = 1'b1;
        w_bit_n   = w_load ? q_in[0] : (w_shift ? w_dout_nxt : w_dout);
        w_last_n  = (w_cnt_n == LAST) && !PARITY_EN;
      end
      PAR: begin
        w_valid_n = 1'b1;
        w_bit_n   = w_par_n;
        w_last_n  = 1'b1;
      end
      default: ;
    endcase

    w_busy_n = (w_state_n != IDLE);
    w_done_n = (w_state_n == DONE);
  end

  assign tx_valid = r_tx_valid;
  assign tx_bit   = r_tx_bit;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_dff_scan_unloader.sv
// Directed bench for dff_scan_unloader: frame table plus reset-abort sequence.
module tb_dff_scan_unloader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cap_a, cap_b, tx_ready;
  logic [7:0] q_in;
  logic       a_valid, a_bit, a_last, a_busy, a_done;
  logic       b_valid, b_bit, b_last, b_busy, b_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_scan_unloader #(.WIDTH(8), .PARITY_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .capture_req(cap_a), .q_in(q_in), .tx_ready(tx_ready),
    .tx_valid(a_valid), .tx_bit(a_bit), .tx_last(a_last), .busy(a_busy), .done(a_done)
  );

  dff_scan_unloader #(.WIDTH(8), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .capture_req(cap_b), .q_in(q_in), .tx_ready(tx_ready),
    .tx_valid(b_valid), .tx_bit(b_bit), .tx_last(b_last), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [7:0] q;
    bit         use_b;
    bit         toggle;       // tx_ready = 1 on even cycles, 0 on odd
    int         inj_cyc;      // cycle of a mid-frame capture_req with q_in=FF (0 = none)
    bit         cap_at_done;  // assert capture_req during the done cycle
    logic [8:0] exp_seq;      // expected serial stream, bit 0 sent first
    int         nbits;
    int         exp_done;     // cycle of done, request cycle = 1
  } frame_t;

  frame_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int id, input frame_t f);
    int   cyc, nacc;
    bit   got_done, prev_stall, rdy;
    logic v, b, l, d, bz, pb, pl;
    q_in     = f.q;
    tx_ready = 1'b1;
    if (f.use_b) cap_b = 1'b1; else cap_a = 1'b1;
    @(posedge clk); #1;
    cap_a = 1'b0; cap_b = 1'b0;
    cyc = 2; nacc = 0; got_done = 1'b0; prev_stall = 1'b0; pb = 1'b0; pl = 1'b0;
    while (!got_done && cyc < 60) begin
      v  = f.use_b ? b_valid : a_valid;
      b  = f.use_b ? b_bit   : a_bit;
      l  = f.use_b ? b_last  : a_last;
      d  = f.use_b ? b_done  : a_done;
      bz = f.use_b ? b_busy  : a_busy;
      if (d) begin
        got_done = 1'b1;
        chk($sformatf("f%0d_done_cyc", id), cyc, f.exp_done);
        chk($sformatf("f%0d_nbits", id), nacc, f.nbits);
        chk($sformatf("f%0d_done_valid", id), v, 1'b0);
        chk($sformatf("f%0d_done_busy", id), bz, 1'b1);
        if (f.cap_at_done) begin
          q_in = 8'h3C;
          if (f.use_b) cap_b = 1'b1; else cap_a = 1'b1;
        end
      end else begin
        chk($sformatf("f%0d_c%0d_valid", id, cyc), v, 1'b1);
        chk($sformatf("f%0d_c%0d_busy", id, cyc), bz, 1'b1);
        if (prev_stall) begin
          chk($sformatf("f%0d_c%0d_hold_bit", id, cyc), b, pb);
          chk($sformatf("f%0d_c%0d_hold_last", id, cyc), l, pl);
        end
        rdy = f.toggle ? (cyc % 2 == 0) : 1'b1;
        if (rdy) begin
          if (nacc < f.nbits) begin
            chk($sformatf("f%0d_bit%0d", id, nacc), b, f.exp_seq[nacc]);
            chk($sformatf("f%0d_last%0d", id, nacc), l, (nacc == f.nbits - 1));
          end else begin
            chk($sformatf("f%0d_extra_bit", id), nacc, f.nbits - 1);
          end
          nacc++;
        end
        prev_stall = !rdy; pb = b; pl = l;
        tx_ready = rdy;
        if (cyc == f.inj_cyc) begin
          q_in  = 8'hFF;
          cap_a = 1'b1;
        end else begin
          cap_a = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("f%0d_done_seen", id), got_done, 1'b1);
    cap_a = 1'b0; cap_b = 1'b0;
    // One cycle after done: single pulse, back to idle, any done-cycle request dropped
    chk($sformatf("f%0d_post_done", id), f.use_b ? b_done : a_done, 1'b0);
    chk($sformatf("f%0d_post_busy", id), f.use_b ? b_busy : a_busy, 1'b0);
    chk($sformatf("f%0d_post_valid", id), f.use_b ? b_valid : a_valid, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 0, 1'b0, 9'h0A5, 9, 11};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 9'h0A5, 9, 19};
    tbl[2] = '{8'hA5, 1'b0, 1'b0, 5, 1'b0, 9'h0A5, 9, 11};
    tbl[3] = '{8'h5A, 1'b0, 1'b0, 0, 1'b1, 9'h05A, 9, 11};
    tbl[4] = '{8'h07, 1'b0, 1'b0, 0, 1'b0, 9'h107, 9, 11};
    tbl[5] = '{8'h80, 1'b1, 1'b0, 0, 1'b0, 9'h080, 8, 10};
    tbl[6] = '{8'h0F, 1'b0, 1'b0, 0, 1'b0, 9'h00F, 9, 11};

    rst = 1'b0; cap_a = 1'b0; cap_b = 1'b0; tx_ready = 1'b0; q_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_outputs", {a_valid, a_bit, a_last, a_busy, a_done}, 5'b0);
    chk("reset_b_outputs", {b_valid, b_bit, b_last, b_busy, b_done}, 5'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_frame(i, tbl[i]);

    // Abort a frame with reset after three bits have been accepted
    @(posedge clk); #1;
    q_in = 8'hA5; tx_ready = 1'b1; cap_a = 1'b1;
    @(posedge clk); #1;
    cap_a = 1'b0;
    chk("rst_seq_bit0", a_bit, 1'b1);
    @(posedge clk); #1;
    chk("rst_seq_bit1", a_bit, 1'b0);
    @(posedge clk); #1;
    chk("rst_seq_bit2", a_bit, 1'b1);
    @(posedge clk); #1;
    chk("rst_seq_busy_before", a_busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_seq_outputs", {a_valid, a_bit, a_last, a_busy, a_done}, 5'b0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_seq_idle%0d", k), {a_valid, a_busy, a_done}, 3'b0);
    end

    run_frame(6, tbl[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
